// File: rtl/wb_stage_if.sv
// Interface for the writeback stage. It carries the MEM/WB inputs, the decode
// read ports and the published writeback and retire state.
interface wb_stage_if;
  logic [31:0] MEM_data;
  logic        MEM_vld;
  logic        MEM_reg_wr;
  logic [4:0]  MEM_rd;
  logic [4:0]  ID_rs1_idx;
  logic [4:0]  ID_rs2_idx;
  logic [31:0] ID_rs1_data;
  logic [31:0] ID_rs2_data;
  logic [31:0] WB_data;
  logic [4:0]  WB_rd;
  logic        WB_wr;
  logic        WB_vld;
  logic [63:0] WB_retired;

  modport master (
    output MEM_data, MEM_vld, MEM_reg_wr, MEM_rd, ID_rs1_idx, ID_rs2_idx,
    input  ID_rs1_data, ID_rs2_data, WB_data, WB_rd, WB_wr, WB_vld, WB_retired
  );

  modport slave (
    input  MEM_data, MEM_vld, MEM_reg_wr, MEM_rd, ID_rs1_idx, ID_rs2_idx,
    output ID_rs1_data, ID_rs2_data, WB_data, WB_rd, WB_wr, WB_vld, WB_retired
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, 32x32 register file, retire counter.
// Define WB_RF_BYPASS_EN to let the read ports see the WB-stage write directly.
module wb_stage (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        vld_q, vld_d;
  logic [63:0] retired_q, retired_d;
  logic [31:0] rf_q [32];
  logic [31:0] rs1_data, rs2_data;

  always_comb begin
    vld_d     = bus.MEM_vld;
    wr_d      = bus.MEM_vld & bus.MEM_reg_wr & (bus.MEM_rd != '0);
    rd_d      = bus.MEM_rd;
    data_d    = bus.MEM_data;
    retired_d = vld_q ? retired_q + 64'd1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      retired_q <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      vld_q     <= vld_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      retired_q <= retired_d;
      if (wr_q) rf_q[rd_q] <= data_q;
    end
  end

  // Reads are masked during reset: the array is only cleared at the reset edge.
  always_comb begin
    rs1_data = rf_q[bus.ID_rs1_idx];
`ifdef WB_RF_BYPASS_EN
    if (wr_q && (rd_q == bus.ID_rs1_idx)) rs1_data = data_q;
`endif
    if (rst || (bus.ID_rs1_idx == '0)) rs1_data = '0;
  end

  always_comb begin
    rs2_data = rf_q[bus.ID_rs2_idx];
`ifdef WB_RF_BYPASS_EN
    if (wr_q && (rd_q == bus.ID_rs2_idx)) rs2_data = data_q;
`endif
    if (rst || (bus.ID_rs2_idx == '0)) rs2_data = '0;
  end

  assign bus.ID_rs1_data = rs1_data;
  assign bus.ID_rs2_data = rs2_data;
  assign bus.WB_data     = data_q;
  assign bus.WB_rd       = rd_q;
  assign bus.WB_wr       = wr_q;
  assign bus.WB_vld      = vld_q;
  assign bus.WB_retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage; expectations follow WB_RF_BYPASS_EN if defined.
module tb_wb_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic vld, input logic wr, input logic [4:0] rd, input logic [31:0] data);
    bus.MEM_vld    = vld;
    bus.MEM_reg_wr = wr;
    bus.MEM_rd     = rd;
    bus.MEM_data   = data;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    bus.ID_rs1_idx = 5'd0;
    bus.ID_rs2_idx = 5'd0;

    // Random traffic before reset so the array holds non-zero data
    for (int i = 0; i < 20; i++) begin
      mem(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end

    // Reset held for two cycles
    rst = 1'b1;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    bus.ID_rs1_idx = 5'd3;
    bus.ID_rs2_idx = 5'd17;
    #1;
    check("rst_read1_held", 64'(bus.ID_rs1_data), 64'h0);
    check("rst_read2_held", 64'(bus.ID_rs2_data), 64'h0);
    tick();
    tick();
    check("rst_wb_vld", 64'(bus.WB_vld), 64'h0);
    check("rst_wb_wr", 64'(bus.WB_wr), 64'h0);
    check("rst_wb_rd", 64'(bus.WB_rd), 64'h0);
    check("rst_wb_data", 64'(bus.WB_data), 64'h0);
    check("rst_retired", bus.WB_retired, 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.ID_rs1_idx = 5'(i);
      bus.ID_rs2_idx = 5'(31 - i);
      #1;
      check("rst_rf_port1", 64'(bus.ID_rs1_data), 64'h0);
      check("rst_rf_port2", 64'(bus.ID_rs2_data), 64'h0);
    end
    tick();

    // Basic write
    mem(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check("basic_wb_wr", 64'(bus.WB_wr), 64'h1);
    check("basic_wb_rd", 64'(bus.WB_rd), 64'd5);
    check("basic_wb_data", 64'(bus.WB_data), 64'hDEADBEEF);
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    bus.ID_rs1_idx = 5'd5;
    #1;
    check("basic_read", 64'(bus.ID_rs1_data), 64'hDEADBEEF);
    check("basic_retired", bus.WB_retired, 64'd1);

    // x0 protection
    mem(1'b1, 1'b1, 5'd0, 32'h12345678);
    tick();
    check("x0_wb_wr", 64'(bus.WB_wr), 64'h0);
    check("x0_wb_vld", 64'(bus.WB_vld), 64'h1);
    bus.ID_rs1_idx = 5'd0;
    #1;
    check("x0_read_wb", 64'(bus.ID_rs1_data), 64'h0);
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("x0_read_after", 64'(bus.ID_rs1_data), 64'h0);
    check("x0_retired", bus.WB_retired, 64'd2);

    // Bubble with reg_wr set
    mem(1'b0, 1'b1, 5'd7, 32'hAAAA5555);
    tick();
    check("bubble_wb_wr", 64'(bus.WB_wr), 64'h0);
    check("bubble_wb_vld", 64'(bus.WB_vld), 64'h0);
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    bus.ID_rs1_idx = 5'd7;
    #1;
    check("bubble_read", 64'(bus.ID_rs1_data), 64'h0);
    check("bubble_retired", bus.WB_retired, 64'd2);

    // Store (valid, no register write)
    mem(1'b1, 1'b0, 5'd7, 32'h5555AAAA);
    tick();
    check("store_wb_wr", 64'(bus.WB_wr), 64'h0);
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("store_read", 64'(bus.ID_rs1_data), 64'h0);
    check("store_retired", bus.WB_retired, 64'd3);

    // Bypass: rf[9]=1 while WB holds a write of 2 to x9
    mem(1'b1, 1'b1, 5'd9, 32'h1);
    tick();
    mem(1'b1, 1'b1, 5'd9, 32'h2);
    tick();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    bus.ID_rs1_idx = 5'd9;
    bus.ID_rs2_idx = 5'd9;
    #1;
`ifdef WB_RF_BYPASS_EN
    check("bypass_port1", 64'(bus.ID_rs1_data), 64'h2);
    check("bypass_port2", 64'(bus.ID_rs2_data), 64'h2);
`else
    check("nobypass_port1", 64'(bus.ID_rs1_data), 64'h1);
    check("nobypass_port2", 64'(bus.ID_rs2_data), 64'h1);
`endif
    tick();
    check("bypass_next_port1", 64'(bus.ID_rs1_data), 64'h2);
    check("bypass_next_port2", 64'(bus.ID_rs2_data), 64'h2);
    check("bypass_retired", bus.WB_retired, 64'd5);

    // Back-to-back writes to x4: last writer wins
    mem(1'b1, 1'b1, 5'd4, 32'h0000AAAA);
    tick();
    mem(1'b1, 1'b1, 5'd4, 32'h0000BBBB);
    tick();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    bus.ID_rs2_idx = 5'd4;
    #1;
    check("b2b_read", 64'(bus.ID_rs2_data), 64'h0000BBBB);
    check("b2b_retired", bus.WB_retired, 64'd7);

    // Counter wrap
    mem(1'b1, 1'b0, 5'd1, 32'h0);
    tick();
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    check("wrap_preload", bus.WB_retired, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("wrap_retired", bus.WB_retired, 64'h0);

    // Reset with a write pending in MEM/WB
    mem(1'b1, 1'b1, 5'd3, 32'hCAFEF00D);
    tick();
    check("midrst_wb_wr_before", 64'(bus.WB_wr), 64'h1);
    rst = 1'b1;
    mem(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b0;
    check("midrst_wb_vld", 64'(bus.WB_vld), 64'h0);
    check("midrst_retired", bus.WB_retired, 64'h0);
    tick();
    bus.ID_rs1_idx = 5'd3;
    bus.ID_rs2_idx = 5'd9;
    #1;
    check("midrst_read3", 64'(bus.ID_rs1_data), 64'h0);
    check("midrst_read9", 64'(bus.ID_rs2_data), 64'h0);
    check("midrst_retired_after", bus.WB_retired, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
